// File: rtl/tmac_uni_param.sv
// -----------------------------------------------------------------------------
// tmac_uni_param
// Temporal-unary multiply-accumulate over LANES lanes of WIDTH-bit unsigned
// operands. One operation is:
//   RUN   : 2^WIDTH cycles. Each lane counts the cycles in which both
//           (c < A) and (bitrev(c) < B) hold. That count is A*B/2^WIDTH in
//           unary form.
//   SUM1  : the lanes are added in groups of four.
//   SUM2  : the group sums are totalled. The result is either scaled
//           (divided by LANES) or saturated to WIDTH bits.
//   EMIT  : 2^WIDTH cycles. The result is regenerated as a unipolar
//           bitstream, oC = (res > bitrev(c)).
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   start      request an operation; honoured only in IDLE
//   scaled     mode, sampled with start (1: divide by LANES, 0: saturate)
//   iA, iB     flattened operands, lane i at [i*WIDTH +: WIDTH]
//   busy       high from the cycle after an accepted start through last EMIT
//   res        binary result, holds until the next result
//   res_valid  one-cycle pulse when res updates
//   ovf        nonscaled sum exceeded 2^WIDTH-1
//   oC         unipolar output bitstream
//   oc_valid   high while oC carries the result stream
// -----------------------------------------------------------------------------
module tmac_uni_param #(
    parameter int WIDTH = 8,
    parameter int LANES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     scaled,
    input  logic [LANES*WIDTH-1:0]   iA,
    input  logic [LANES*WIDTH-1:0]   iB,
    output logic                     busy,
    output logic [WIDTH-1:0]         res,
    output logic                     res_valid,
    output logic                     ovf,
    output logic                     oC,
    output logic                     oc_valid
);

    localparam int LG     = $clog2(LANES);
    localparam int GROUPS = LANES / 4;
    localparam int PW     = WIDTH + 2;
    localparam int SW     = WIDTH + LG;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_SUM1 = 3'd2;
    localparam logic [2:0] S_SUM2 = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;

    localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    S_MAX  = SW'(C_MAX);

    // Sobol dimension 1 is the bit-reversed counter.
    function automatic logic [WIDTH-1:0] f_bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] o;
        for (int k = 0; k < WIDTH; k++) begin
            o[k] = v[WIDTH-1-k];
        end
        return o;
    endfunction

    logic [2:0]             r_state;
    logic [WIDTH-1:0]       r_c;
    logic [LANES*WIDTH-1:0] r_a;
    logic [LANES*WIDTH-1:0] r_b;
    logic                   r_scaled;
    logic [WIDTH-1:0]       r_cnt [LANES];
    logic [PW-1:0]          r_part [GROUPS];
    logic                   r_busy;
    logic [WIDTH-1:0]       r_res;
    logic                   r_res_valid;
    logic                   r_ovf;
    logic                   r_oc;
    logic                   r_oc_valid;

    logic [WIDTH-1:0]       w_r;
    logic [WIDTH-1:0]       w_c_inc;
    logic [LANES-1:0]       w_m;
    logic [PW-1:0]          w_part [GROUPS];
    logic [SW-1:0]          w_sum;
    logic [WIDTH-1:0]       w_res_next;
    logic                   w_ovf_next;
    logic                   w_oc_next;

    // Sequence value, next counter value and per-lane unary product bits.
    always_comb begin
        w_r     = f_bitrev(r_c);
        w_c_inc = r_c + C_ONE;
        w_m     = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_m[i] = (r_c < r_a[i*WIDTH +: WIDTH]) & (w_r < r_b[i*WIDTH +: WIDTH]);
        end
        // The EMIT bit for the next cycle is computed one cycle ahead so that oC can be registered.
        w_oc_next = (r_res > f_bitrev(w_c_inc));
    end

    // Group-of-four partial sums, the total, and the scale/saturate stage.
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            w_part[g] = PW'(r_cnt[4*g]) + PW'(r_cnt[4*g+1])
                      + PW'(r_cnt[4*g+2]) + PW'(r_cnt[4*g+3]);
        end
        w_sum = {SW{1'b0}};
        for (int g = 0; g < GROUPS; g++) begin
            w_sum = w_sum + SW'(r_part[g]);
        end
        if (r_scaled) begin
            w_res_next = w_sum[SW-1:LG];
            w_ovf_next = 1'b0;
        end else if (w_sum > S_MAX) begin
            w_res_next = C_MAX;
            w_ovf_next = 1'b1;
        end else begin
            w_res_next = w_sum[WIDTH-1:0];
            w_ovf_next = 1'b0;
        end
    end

    // Control FSM, lane counters, sum pipeline and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_c         <= C_ZERO;
            r_a         <= {(LANES*WIDTH){1'b0}};
            r_b         <= {(LANES*WIDTH){1'b0}};
            r_scaled    <= 1'b0;
            r_busy      <= 1'b0;
            r_res       <= C_ZERO;
            r_res_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_oc        <= 1'b0;
            r_oc_valid  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= C_ZERO;
            end
            for (int g = 0; g < GROUPS; g++) begin
                r_part[g] <= {PW{1'b0}};
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_res_valid <= 1'b0;
                    r_oc        <= 1'b0;
                    r_oc_valid  <= 1'b0;
                    if (start) begin
                        r_a      <= iA;
                        r_b      <= iB;
                        r_scaled <= scaled;
                        r_c      <= C_ZERO;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                        for (int i = 0; i < LANES; i++) begin
                            r_cnt[i] <= C_ZERO;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_cnt[i] <= r_cnt[i] + WIDTH'(w_m[i]);
                    end
                    // The counter wraps to zero on the last RUN cycle.
                    r_c <= w_c_inc;
                    if (r_c == C_MAX) begin
                        r_state <= S_SUM1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_SUM1: begin
                    for (int g = 0; g < GROUPS; g++) begin
                        r_part[g] <= w_part[g];
                    end
                    r_state <= S_SUM2;
                end
                S_SUM2: begin
                    r_res       <= w_res_next;
                    r_ovf       <= w_ovf_next;
                    r_res_valid <= 1'b1;
                    // bitrev(0) is 0, so the first EMIT bit is simply res != 0.
                    r_oc        <= (w_res_next != C_ZERO);
                    r_oc_valid  <= 1'b1;
                    r_c         <= C_ZERO;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    r_res_valid <= 1'b0;
                    r_c         <= w_c_inc;
                    if (r_c == C_MAX) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_oc       <= 1'b0;
                        r_oc_valid <= 1'b0;
                    end else begin
                        r_oc <= w_oc_next;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_oc        <= 1'b0;
                    r_oc_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign ovf       = r_ovf;
    assign oC        = r_oc;
    assign oc_valid  = r_oc_valid;

endmodule

// File: tb/tb_tmac_uni_param.sv
// -----------------------------------------------------------------------------
// tb_tmac_uni_param
// Directed and randomised operations on tmac_uni_param (WIDTH=8, LANES=16).
// The reference model counts the lane products directly from the arithmetic
// definition, and the expected result stream is derived from that model.
// -----------------------------------------------------------------------------
module tb_tmac_uni_param;

    localparam int W  = 8;
    localparam int L  = 16;
    localparam int P  = 256;
    localparam int LAT = P + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           scaled;
    logic [L*W-1:0] iA;
    logic [L*W-1:0] iB;
    logic           busy;
    logic [W-1:0]   res;
    logic           res_valid;
    logic           ovf;
    logic           oC;
    logic           oc_valid;

    int n_cmp = 0;
    int n_bad = 0;

    tmac_uni_param #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scaled    (scaled),
        .iA        (iA),
        .iB        (iB),
        .busy      (busy),
        .res       (res),
        .res_valid (res_valid),
        .ovf       (ovf),
        .oC        (oC),
        .oc_valid  (oc_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int v);
        int r = 0;
        for (int k = 0; k < W; k++) begin
            if (((v >> k) & 1) != 0) r = r | (1 << (W - 1 - k));
        end
        return r;
    endfunction

    // Reference: lane count = #{c in period : c < A and rev(c) < B}.
    task automatic model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                         input bit sc, output int r, output int o);
        int s = 0;
        for (int i = 0; i < L; i++) begin
            int av = int'(a[i*W +: W]);
            int bv = int'(b[i*W +: W]);
            for (int c = 0; c < P; c++) begin
                if (c < av && rev(c) < bv) s++;
            end
        end
        if (sc) begin
            r = s / L;
            o = 0;
        end else begin
            r = (s > P - 1) ? P - 1 : s;
            o = (s > P - 1) ? 1 : 0;
        end
    endtask

    function automatic logic [L*W-1:0] rand_vec(input int maxv);
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(maxv, 0));
        return v;
    endfunction

    function automatic logic [L*W-1:0] lane0(input int a);
        logic [L*W-1:0] v = '0;
        v[W-1:0] = W'(a);
        return v;
    endfunction

    // One full operation. The task starts and ends on a negedge, so back-to-back
    // calls start in the same cycle that busy falls.
    task automatic run_op(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                          input bit sc, input bit churn, input bit poke);
        int er, eo, ones;
        model(a, b, sc, er, eo);
        iA = a; iB = b; scaled = sc; start = 1'b1;
        @(posedge clk);
        ones = 0;
        for (int k = 1; k <= 2 * P + 3; k++) begin
            @(negedge clk);
            chk("busy", busy, 32'(k <= 2 * P + 2));
            chk("res_valid", res_valid, 32'(k == LAT));
            if (k == LAT) begin
                chk("res", res, er);
                chk("ovf", ovf, eo);
            end
            if (k >= LAT && k <= 2 * P + 2) begin
                chk("oc_valid", oc_valid, 1);
                chk("oC", oC, 32'(er > rev(k - LAT)));
                ones += int'(oC);
            end else begin
                chk("oc_valid_idle", oc_valid, 0);
                chk("oC_idle", oC, 0);
            end
            if (k == 1) start = 1'b0;
            if (churn) begin
                iA = rand_vec(P - 1); iB = rand_vec(P - 1); scaled = 1'($urandom);
            end
            if (poke && (k == 100 || k == 300)) begin
                start = 1'b1; iA = rand_vec(P - 1); iB = rand_vec(P - 1); scaled = ~sc;
            end
            if (poke && (k == 101 || k == 301)) start = 1'b0;
        end
        chk("ones", ones, er);
    endtask

    initial begin
        logic [L*W-1:0] ones_v;
        ones_v = '1;
        rst = 1'b1; start = 1'b0; scaled = 1'b0; iA = '0; iB = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_res", res, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_oC", oC, 0);
        chk("rst_oc_valid", oc_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero operands
        run_op('0, '0, 1'b0, 1'b0, 1'b0);
        // Single lane, both modes
        run_op(lane0(128), lane0(128), 1'b0, 1'b0, 1'b0);
        run_op(lane0(128), lane0(128), 1'b1, 1'b0, 1'b0);
        // Saturation, both modes
        run_op(ones_v, ones_v, 1'b0, 1'b0, 1'b0);
        run_op(ones_v, ones_v, 1'b1, 1'b0, 1'b0);
        // Start pulses while busy are ignored
        run_op(rand_vec(60), rand_vec(60), 1'b0, 1'b0, 1'b1);
        // Operands churn during the operation
        run_op(rand_vec(P - 1), rand_vec(P - 1), 1'b1, 1'b1, 1'b0);
        run_op(rand_vec(70), rand_vec(70), 1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN
        iA = rand_vec(P - 1); iB = rand_vec(P - 1); scaled = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_oC", oC, 0);
        chk("mid_rst_oc_valid", oc_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            chk("post_rst_res_valid", res_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_op(lane0(128), lane0(128), 1'b0, 1'b0, 1'b0);

        // Randomised operations, small and full operand ranges
        for (int n = 0; n < 4; n++) begin
            int maxv;
            maxv = (n % 2 == 0) ? 63 : P - 1;
            run_op(rand_vec(maxv), rand_vec(maxv), 1'($urandom), 1'b0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmac_uni_param.md
Name: tmac_uni_param

Overview:
- Parametrised temporal-unary multiply-accumulate over LANES lanes of WIDTH-bit unsigned operands.
- Successor to the fixed 16-lane, 8-bit nonscaled MAC, adding:
  - run-time scaled/nonscaled mode
  - a saturating accumulate with overflow flag
  - an explicit start/busy handshake
  - a binary result alongside the regenerated unipolar output bitstream
- Sits between operand buffers and downstream stochastic consumers in the MAC array.

Parameters:
- WIDTH, 8, operand/result bit width; one bitstream period = 2^WIDTH cycles.
- LANES, 16, number of multiply lanes; must be a power of two, >= 4.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a MAC operation; honoured only in IDLE
- scaled  input  1  mode, sampled with start: 1 = result divided by LANES, 0 = saturating sum
- iA  input  LANES*WIDTH  flattened A operands; lane i at bits [i*WIDTH +: WIDTH]
- iB  input  LANES*WIDTH  flattened B operands; same packing
- busy  output  1  high from the cycle after an accepted start through the last EMIT cycle
- res  output  WIDTH  binary MAC result; holds until the next result
- res_valid  output  1  one-cycle pulse when res updates
- ovf  output  1  nonscaled sum exceeded 2^WIDTH-1; updates with res
- oC  output  1  unipolar output bitstream
- oc_valid  output  1  high while oC carries the result stream

Behaviour:
- Reset (async, any state): state=IDLE; all counters, lane counts and partial sums = 0; busy, res, res_valid, ovf, oC, oc_valid = 0.
- Internal period counter c (WIDTH bits). Sequence value r = bit-reverse(c), which is Sobol dimension 1 for WIDTH bits.
- FSM state IDLE:
  - start=1 in cycle t: register iA, iB and scaled; clear lane counts; c=0; go to RUN.
  - start in any other state is ignored, with no queueing.
- FSM state RUN (cycles t+1 .. t+2^WIDTH, c = 0 .. 2^WIDTH-1):
  - lane bit m_i = (c < A_i) & (r < B_i).
  - cnt_i += m_i; cnt_i is WIDTH bits and cannot overflow, since its maximum is 2^WIDTH-1.
  - After c = 2^WIDTH-1, go to SUM1.
  - Operand inputs may change freely during RUN; only the registered copies are used.
- FSM state SUM1 (1 cycle): partial sums over groups of 4 consecutive lanes, each WIDTH+2 bits.
- FSM state SUM2 (1 cycle):
  - total S = sum of partials, WIDTH+log2(LANES) bits, no wrap.
  - scaled=1: res = S >> log2(LANES) (floor); ovf = 0.
  - scaled=0: res = min(S, 2^WIDTH-1); ovf = (S > 2^WIDTH-1).
  - res, ovf and res_valid are registered, so they are visible in cycle t+2^WIDTH+3.
  - Go to EMIT with c = 0.
- FSM state EMIT (2^WIDTH cycles, starting in cycle t+2^WIDTH+3):
  - oC = (res > r); oc_valid = 1.
  - res_valid is high in the first EMIT cycle only.
  - Ones count over the period equals res exactly, because r is a permutation of 0..2^WIDTH-1.
  - After the last cycle, go to IDLE.
  - In IDLE, oC = 0 and oc_valid = 0.
- busy falls in the cycle after the last EMIT cycle, i.e. t+2*2^WIDTH+3. start may be accepted in that same cycle.
- Total latency, start to res_valid: 2^WIDTH+3 cycles.
- A_i = 0 or B_i = 0 forces the lane count to 0. A_i = B_i = 2^WIDTH-1 gives a lane count of 2^WIDTH-1.
- Reset asserted mid-RUN, SUM or EMIT aborts immediately to the reset state. After reset release the block waits for a new start.

Test Plan (WIDTH=8, LANES=16):
- Zero operands: all iA=0, iB=0, scaled=0, start -> res_valid at start+259 with res=0, ovf=0; 256 EMIT cycles with oC=0 and oc_valid=1; busy low at start+515.
- Single lane: lane0 A=128, B=128, others 0, scaled=0 -> res=64, ovf=0; oC ones count = 64 over the EMIT window. Same operands with scaled=1 -> res=4.
- Saturation: all lanes A=255, B=255, so each lane count = 255 and S = 4080.
  - scaled=0 -> res=255, ovf=1, oC high 255 of 256 cycles.
  - scaled=1 -> res=255, ovf=0.
- Start while busy: pulse start during RUN and during EMIT with different operands -> ignored; result matches the first operands. A start in the cycle busy falls is accepted.
- Reset mid-operation: assert rst at start+100 for 1 cycle -> all outputs 0 immediately; no res_valid follows. A subsequent start with lane0 A=128, B=128 -> res=64.
- Operand change during RUN: change iA/iB on every cycle after start -> result equals the values captured at start.
